// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: frame bit levels,
// the default word width and the receiver state encoding.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/rxlogic_if.sv
// Serial input, FIFO back-pressure and the word/flag outputs of the UART receiver.
interface rxlogic_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  rx;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  receiving;
    logic                  frame_err;
    logic                  overrun_err;

    modport slave (
        input  rx,
        input  fifo_full,
        output data_out,
        output data_valid,
        output receiving,
        output frame_err,
        output overrun_err
    );

    modport master (
        output rx,
        output fifo_full,
        input  data_out,
        input  data_valid,
        input  receiving,
        input  frame_err,
        input  overrun_err
    );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus falling-edge detect.
// Every flop resets to the idle line level so reset never looks like a start edge.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_p0;
    logic rx_p1;
    logic rx_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            // p0: metastability catch, p1: synchronized line, p2: previous sample
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign rx_s = rx_p1;
    assign fall = rx_p2 & ~rx_p1;

endmodule

// File: rtl/rxlogic.sv
// UART receiver: finds start/data/stop frames on the oversampled rx line, votes each
// bit from three samples around its centre and hands completed words to the RX FIFO.
module rxlogic
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    rxlogic_if.slave  bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE * (DATA_WIDTH + 2));
    localparam int BIT_W = $clog2(DATA_WIDTH + 2);
    localparam int HALF  = OVERSAMPLE / 2;

    logic rx_s;
    logic fall;

    rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (bus.rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    rx_state_e             state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n, dec_at;
    logic [BIT_W-1:0]      bit_k, bit_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n, dout_n;
    logic [1:0]            hist;
    logic                  dv_n, fe_n, oe_n, recv;
    logic                  dec, vote;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // cnt is zero in the cycle after the edge, so the decision cycle C_k+1 lands on cnt == HALF + k*OVERSAMPLE
    assign dec_at = CNT_W'(HALF + int'(bit_k) * OVERSAMPLE);
    assign dec    = (cnt == dec_at);
    assign vote   = vote3(hist[1], hist[0], rx_s);

    assign bus.receiving = recv;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_k;
        shreg_n = shreg;
        dout_n  = bus.data_out;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
        recv    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (fall) begin
                    state_n = RX_START;
                    recv    = 1'b1;
                end
            end
            RX_START: begin
                recv = 1'b1;
                if (dec) begin
                    if (vote != START_BIT) begin
                        state_n = RX_IDLE;
                        recv    = 1'b0;
                    end else begin
                        state_n = RX_DATA;
                        bit_n   = bit_k + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                recv = 1'b1;
                if (dec) begin
                    shreg_n = {vote, shreg[DATA_WIDTH-1:1]};
                    bit_n   = bit_k + 1'b1;
                    if (bit_k == BIT_W'(DATA_WIDTH)) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                recv = 1'b1;
                if (dec) begin
                    // Returning to IDLE here leaves room for a back-to-back start edge
                    recv    = 1'b0;
                    state_n = RX_IDLE;
                    if (vote != STOP_BIT) begin
                        fe_n    = 1'b1;
                        state_n = RX_BREAK;
                    end else if (bus.fifo_full) begin
                        oe_n = 1'b1;
                    end else begin
                        dout_n = shreg;
                        dv_n   = 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RX_IDLE;
            cnt             <= '0;
            bit_k           <= '0;
            hist            <= 2'b11;
            bus.data_out    <= '0;
            bus.data_valid  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bit_k           <= bit_n;
            hist            <= {hist[0], rx_s};
            bus.data_out    <= dout_n;
            bus.data_valid  <= dv_n;
            bus.frame_err   <= fe_n;
            bus.overrun_err <= oe_n;
        end
    end

    // The shift register carries only data; a reset mid-frame simply abandons it
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

endmodule

// File: tb/tb_rxlogic.sv
// Self-checking bench for rxlogic: directed frames, a vector table and a randomized
// run compared against a frame-level model of the receive rules.
module tb_rxlogic;

    localparam int DW   = 8;
    localparam int OS   = 16;
    localparam int MAXC = 40000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic ff = 1'b0;
    logic ff_fixed = 1'b0;
    logic rand_ff = 1'b0;

    always #5 clk = ~clk;

    rxlogic_if #(.DATA_WIDTH(DW)) rif ();
    assign rif.rx        = rx;
    assign rif.fifo_full = ff;

    rxlogic #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    int cyc = 0;
    bit rx_log[MAXC];
    bit ff_log[MAXC];

    always @(posedge clk) begin
        if (cyc < MAXC) begin
            rx_log[cyc] <= rx;
            ff_log[cyc] <= ff;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) ff <= rand_ff ? ($urandom_range(0, 3) == 0) : ff_fixed;

    int          dv_cyc[$], fe_cyc[$], oe_cyc[$], rf_cyc[$];
    logic [7:0]  dv_word[$];
    logic        recv_q = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rif.data_valid) begin
                dv_cyc.push_back(cyc);
                dv_word.push_back(rif.data_out);
            end
            if (rif.frame_err)   fe_cyc.push_back(cyc);
            if (rif.overrun_err) oe_cyc.push_back(cyc);
            if (recv_q && !rif.receiving) rf_cyc.push_back(cyc);
        end
        recv_q <= rif.receiving;
    end

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int wat(input logic [7:0] q[$], input int i);
        if (i < q.size()) return int'(q[i]);
        return -1;
    endfunction

    task automatic clear_ev();
        dv_cyc.delete(); dv_word.delete(); fe_cyc.delete(); oe_cyc.delete(); rf_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
    endtask

    // gk/goff: invert one cycle at offset goff of bit gk (gk < 0: no glitch)
    task automatic send_frame(input logic [7:0] w, input logic stop, input int gk,
                              input int goff, output int t0);
        logic [9:0] bits;
        bits = {stop, w, 1'b0};
        t0 = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < OS; j++) begin
                @(negedge clk);
                if (k == 0 && j == 0) t0 = cyc + 2;
                rx = bits[k] ^ ((k == gk) && (j == goff));
            end
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         e_dv_cyc[$], e_fe_cyc[$], e_oe_cyc[$];
    logic [7:0] e_dv_word[$];

    function automatic bit rxs(input int t);
        if (t < 2) return 1'b1;
        return rx_log[t-2];
    endfunction

    function automatic bit maj(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic run_model(input int from, input int to);
        int t;
        t = from + 1;
        e_dv_cyc.delete(); e_dv_word.delete(); e_fe_cyc.delete(); e_oe_cyc.delete();
        while (t < to) begin
            if (rxs(t) == 1'b0 && rxs(t-1) == 1'b1 && (t + OS/2 + (DW+1)*OS + 4) < to) begin
                int         c, dec, u;
                bit         v, aborted;
                logic [7:0] w;
                w = '0; v = 1'b0; aborted = 1'b0; dec = t;
                for (int k = 0; k <= DW + 1 && !aborted; k++) begin
                    c   = t + OS/2 + k*OS;
                    v   = maj(rxs(c-1), rxs(c), rxs(c+1));
                    dec = c + 1;
                    if (k == 0 && v) aborted = 1'b1;
                    if (k >= 1 && k <= DW) w[k-1] = v;
                end
                if (aborted) begin
                    t = dec + 1;
                end else if (!v) begin
                    e_fe_cyc.push_back(dec + 1);
                    u = dec + 1;
                    while (u < to && !rxs(u)) u++;
                    t = u + 1;
                end else if (ff_log[dec]) begin
                    e_oe_cyc.push_back(dec + 1);
                    t = dec + 1;
                end else begin
                    e_dv_cyc.push_back(dec + 1);
                    e_dv_word.push_back(w);
                    t = dec + 1;
                end
            end else begin
                t++;
            end
        end
    endtask

    typedef struct {
        logic [7:0] word;
        bit         stop;
        bit         ffull;
        int         low_hold;
        bit         e_dv;
        bit         e_fe;
        bit         e_oe;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vt[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t0b, s, ev;
        logic [9:0] pb;

        vt[0] = '{8'h3C, 1'b0, 1'b0, 40, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[1] = '{8'h5A, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h5A};
        vt[2] = '{8'h0F, 1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b1, 8'h5A};
        vt[3] = '{8'hC3, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'hC3};
        vt[4] = '{8'h00, 1'b0, 1'b1, 0,  1'b0, 1'b1, 1'b0, 8'hC3};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_data_out",    int'(rif.data_out), 0);
        chk("reset_data_valid",  int'(rif.data_valid), 0);
        chk("reset_receiving",   int'(rif.receiving), 0);
        chk("reset_frame_err",   int'(rif.frame_err), 0);
        chk("reset_overrun_err", int'(rif.overrun_err), 0);
        rst = 1'b0;
        idle(10);

        // ideal 0xA5 frame: latency and receiving fall
        clear_ev();
        send_frame(8'hA5, 1'b1, -1, 0, t0);
        idle(20);
        chk("t1_dv_count", dv_cyc.size(), 1);
        chk("t1_dv_cycle", qat(dv_cyc, 0) - t0, 154);
        chk("t1_word", wat(dv_word, 0), 'hA5);
        chk("t1_fe_count", fe_cyc.size(), 0);
        chk("t1_oe_count", oe_cyc.size(), 0);
        chk("t1_recv_fall", qat(rf_cyc, 0) - t0, 153);
        chk("t1_data_out", int'(rif.data_out), 'hA5);

        // short low glitch in idle is rejected
        clear_ev();
        @(negedge clk);
        t0 = cyc + 2;
        rx = 1'b0;
        hold_low(2);
        idle(20);
        chk("t2_recv_pulses", rf_cyc.size(), 1);
        chk("t2_recv_back_by_10", int'(qat(rf_cyc, 0) >= t0 && qat(rf_cyc, 0) <= t0 + 10), 1);
        chk("t2_dv_count", dv_cyc.size(), 0);
        chk("t2_fe_count", fe_cyc.size(), 0);
        chk("t2_oe_count", oe_cyc.size(), 0);

        // vector table: framing error with break, overrun, priority
        for (int i = 0; i < 5; i++) begin
            ff_fixed = vt[i].ffull;
            idle(3);
            clear_ev();
            send_frame(vt[i].word, vt[i].stop, -1, 0, t0);
            hold_low(vt[i].low_hold);
            ff_fixed = 1'b0;
            idle(25);
            chk($sformatf("vec%0d_dv_count", i), dv_cyc.size(), int'(vt[i].e_dv));
            chk($sformatf("vec%0d_fe_count", i), fe_cyc.size(), int'(vt[i].e_fe));
            chk($sformatf("vec%0d_oe_count", i), oe_cyc.size(), int'(vt[i].e_oe));
            chk($sformatf("vec%0d_data_out", i), int'(rif.data_out), int'(vt[i].e_dout));
            ev = vt[i].e_dv ? qat(dv_cyc, 0) : (vt[i].e_fe ? qat(fe_cyc, 0) : qat(oe_cyc, 0));
            chk($sformatf("vec%0d_event_cycle", i), ev - t0, 154);
            if (vt[i].e_dv) chk($sformatf("vec%0d_word", i), wat(dv_word, 0), int'(vt[i].word));
        end

        // back-to-back 0x00 then 0xFF with a glitch at the centre of bit 3
        idle(5);
        clear_ev();
        send_frame(8'h00, 1'b1, -1, 0, t0);
        send_frame(8'hFF, 1'b1, 3, 8, t0b);
        idle(20);
        chk("t6_dv_count", dv_cyc.size(), 2);
        chk("t6_first_cycle", qat(dv_cyc, 0) - t0, 154);
        chk("t6_second_cycle", qat(dv_cyc, 1) - t0, 160 + 154);
        chk("t6_first_word", wat(dv_word, 0), 'h00);
        chk("t6_second_word", wat(dv_word, 1), 'hFF);
        chk("t6_fe_count", fe_cyc.size(), 0);

        // reset during data bit 4, then a clean 0x81
        pb = {1'b1, 8'h77, 1'b0};
        for (int i = 0; i < 5*OS + OS/2; i++) begin
            @(negedge clk);
            rx = pb[i / OS];
        end
        chk("t5_recv_before_rst", int'(rif.receiving), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_data_out",    int'(rif.data_out), 0);
        chk("t5_rst_data_valid",  int'(rif.data_valid), 0);
        chk("t5_rst_receiving",   int'(rif.receiving), 0);
        chk("t5_rst_frame_err",   int'(rif.frame_err), 0);
        chk("t5_rst_overrun_err", int'(rif.overrun_err), 0);
        idle(3);
        rst = 1'b0;
        clear_ev();
        idle(10);
        send_frame(8'h81, 1'b1, -1, 0, t0);
        idle(20);
        chk("t5_dv_count", dv_cyc.size(), 1);
        chk("t5_dv_cycle", qat(dv_cyc, 0) - t0, 154);
        chk("t5_word", wat(dv_word, 0), 'h81);
        chk("t5_fe_count", fe_cyc.size(), 0);
        chk("t5_oe_count", oe_cyc.size(), 0);

        // randomized frames, glitches, gaps and fifo_full against the model
        idle(5);
        s = cyc;
        clear_ev();
        rand_ff = 1'b1;
        for (int f = 0; f < 25; f++) begin
            logic [7:0] w;
            logic       stp;
            int         gk, go;
            w   = 8'($urandom);
            stp = ($urandom_range(0, 5) != 0);
            gk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
            go  = int'($urandom_range(0, OS - 1));
            send_frame(w, stp, gk, go, t0);
            if (!stp) hold_low(int'($urandom_range(0, 30)));
            idle(int'($urandom_range(0, 20)));
        end
        idle(200);
        rand_ff = 1'b0;
        run_model(s, cyc);
        chk("rand_dv_count", dv_cyc.size(), e_dv_cyc.size());
        chk("rand_fe_count", fe_cyc.size(), e_fe_cyc.size());
        chk("rand_oe_count", oe_cyc.size(), e_oe_cyc.size());
        for (int i = 0; i < e_dv_cyc.size(); i++) begin
            chk($sformatf("rand_dv%0d_cycle", i), qat(dv_cyc, i), e_dv_cyc[i]);
            chk($sformatf("rand_dv%0d_word", i), wat(dv_word, i), int'(e_dv_word[i]));
        end
        for (int i = 0; i < e_fe_cyc.size(); i++)
            chk($sformatf("rand_fe%0d_cycle", i), qat(fe_cyc, i), e_fe_cyc[i]);
        for (int i = 0; i < e_oe_cyc.size(); i++)
            chk($sformatf("rand_oe%0d_cycle", i), qat(oe_cyc, i), e_oe_cyc[i]);
        if (e_dv_word.size() > 0)
            chk("rand_final_data_out", int'(rif.data_out), int'(e_dv_word[e_dv_word.size()-1]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
